fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage feeding the opcode decoder. Holds the PC, issues word reads to
//   instruction memory over a req/ack handshake and presents one fetched instruction
//   (instr_o[31:26] drives the decoder opcode input) plus its PC and PC+4.
//   Takes branch redirects from the execute/branch-resolution logic downstream.
// PARAMETERS
//   PC_WIDTH     32     PC and memory address width
//   INSTR_WIDTH  32     instruction word width
//   RESET_PC     0      PC loaded on reset; bits [1:0] must be 0
// PORTS
//   clk_i          in   1            clock, all state on rising edge
//   rst_i          in   1            asynchronous reset, active-low
//   imem_req_o     out  1            read request to instruction memory
//   imem_addr_o    out  PC_WIDTH     read address, equals pc_q
//   imem_ack_i     in   1            read complete; imem_data_i valid this cycle
//   imem_data_i    in   INSTR_WIDTH  read data
//   valid_o        out  1            instr_o/pc_o/pc_plus4_o hold a live instruction
//   instr_o        out  INSTR_WIDTH  fetched instruction
//   pc_o           out  PC_WIDTH     address of instr_o
//   pc_plus4_o     out  PC_WIDTH     pc_o + 4, base for branch-target adder
//   stall_i        in   1            downstream cannot consume; hold outputs
//   redirect_i     in   1            branch taken; refetch from redirect_pc_i
//   redirect_pc_i  in   PC_WIDTH     target; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//   Reset (rst_i=0, async): pc_q=RESET_PC, state=F_IDLE, kill_q=0, imem_req_o=0,
//     valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0. Outstanding request abandoned;
//     instruction memory shares rst_i and drops it too.
//   Consume: instruction accepted by downstream in a cycle with valid_o=1 and stall_i=0.
//   FSM (registered, 3 states):
//     F_IDLE : first cycle after reset release; -> F_FETCH.
//     F_FETCH: imem_req_o=1, imem_addr_o=pc_q held stable until imem_ack_i=1; valid_o=0.
//       ack & !kill_q & !redirect_i: load instr_o=imem_data_i, pc_o=pc_q,
//         pc_plus4_o=pc_q+4, valid_o=1, pc_q<=pc_q+4; -> F_FULL.
//       ack & (kill_q | redirect_i): discard data, kill_q<=0; stay F_FETCH; new request
//         at pc_q (already-updated target) issued next cycle (req drops for 1 cycle).
//     F_FULL : valid_o=1, imem_req_o=0, outputs frozen while stall_i=1.
//       consume -> valid_o<=0; -> F_FETCH (next request starts the following cycle).
//   Redirect (priority over stall and ack capture), any state:
//     pc_q <= {redirect_pc_i[PC_WIDTH-1:2],2'b00}.
//     F_FULL : valid_o<=0 (instruction flushed even if stall_i=1); -> F_FETCH.
//     F_FETCH without ack: request already in flight stays asserted at old address
//       until ack (protocol: addr never changes mid-request); kill_q<=1.
//     Repeated redirects while kill_q=1: last target wins, single kill.
//   Latency: ack cycle -> valid_o=1 next cycle. Min issue-to-issue = mem latency + 2.
//   Arithmetic: pc+4 modulo 2^PC_WIDTH; 32'hFFFF_FFFC wraps to 0, no flag.
//   imem_ack_i while imem_req_o=0: ignored. No outputs combinational from inputs.
// STRUCTURE
//   Shared package cpu_pkg: INSTR_WIDTH, OPCODE_MSB/LSB (31/26), RESET_PC default,
//     fetch_state_t {F_IDLE, F_FETCH, F_FULL}.
//   One sub-module: program_counter (pc_q register; load / +4 / hold, async active-low
//     reset to RESET_PC). FSM, kill flag and output register stay in fetch_unit.
// TESTING
//   1 Reset, 1-cycle-ack memory, stall_i=0: addresses 0,4,8,C issued; instr_o/pc_o match
//     memory image; valid_o pulses each fetch; pc_plus4_o = pc_o+4.
//   2 Stall: valid_o=1 pc_o=8, hold stall_i=1 for 5 cycles -> outputs frozen, imem_req_o=0;
//     release -> next request addr 0xC.
//   3 Redirect in F_FULL with stall_i=1, redirect_pc_i=0x103 -> valid_o=0 next cycle;
//     next request addr 0x100.
//   4 Redirect mid-request (3-cycle ack, addr 0x10) to 0x40 -> addr 0x10 held to ack,
//     data discarded (valid_o stays 0); next request addr 0x40.
//   5 Redirect same cycle as ack, then second redirect during kill -> only last target
//     fetched; no stale instruction ever with valid_o=1.
//   6 rst_i asserted mid-request and during F_FULL -> all outputs 0 immediately (async);
//     release -> fetch restarts at RESET_PC; PC 0xFFFFFFFC +4 wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
//============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU constants and the fetch-stage state type.
// Revision : 1.0 - initial release
//============================================================================
package cpu_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FETCH = 2'd1,
        F_FULL  = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
//============================================================================
// Module   : program_counter
// Purpose  : PC register with load / +4 / hold; load wins over increment.
// Revision : 1.0 - initial release
//============================================================================
module program_counter #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(cpu_pkg::RESET_PC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [PC_WIDTH-1:0] load_pc_i,
    input  logic                inc_i,
    output logic [PC_WIDTH-1:0] pc_o
);
    import cpu_pkg::*;

    localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0] r_pc;

    // PC update: redirect load has priority, otherwise step by one word (wraps)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc <= RESET_PC;
        end else if (load_i) begin
            r_pc <= load_pc_i;
        end else if (inc_i) begin
            r_pc <= r_pc + c_pc_step;
        end
    end

    assign pc_o = r_pc;

endmodule : program_counter
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Issues word reads over req/ack, holds
//            one fetched instruction for the decoder, handles branch
//            redirects (including kill of an in-flight request).
// Revision : 1.0 - initial release
//============================================================================
module fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(cpu_pkg::RESET_PC)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INSTR_WIDTH-1:0] imem_data_i,
    output logic                   valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [PC_WIDTH-1:0]    pc_plus4_o,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i
);
    import cpu_pkg::*;

    localparam logic [PC_WIDTH-1:0] c_align_mask = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] c_pc_step    = PC_WIDTH'(4);

    fetch_state_t r_state, w_state_next;

    logic                   r_kill, w_kill_next;
    logic                   r_drop, w_drop_next;
    logic [PC_WIDTH-1:0]    r_kill_addr, w_kill_addr_next;
    logic                   r_valid, w_valid_next;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pc_out;
    logic [PC_WIDTH-1:0]    r_pc_plus4;

    logic [PC_WIDTH-1:0]    w_pc;
    logic [PC_WIDTH-1:0]    w_redirect_pc;
    logic                   w_req;
    logic                   w_ack;
    logic                   w_capture;

    assign w_redirect_pc = redirect_pc_i & c_align_mask;

    // r_drop forces one idle cycle after a discarded ack so the memory sees
    // the old request end before the refetch begins.
    assign w_req     = (r_state == F_FETCH) && !r_drop;
    assign w_ack     = imem_ack_i && w_req;
    assign w_capture = w_ack && !r_kill && !redirect_i;

    program_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (redirect_i),
        .load_pc_i (w_redirect_pc),
        .inc_i     (w_capture),
        .pc_o      (w_pc)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, kill bookkeeping and valid control
    always_comb begin
        w_state_next     = r_state;
        w_kill_next      = r_kill;
        w_kill_addr_next = r_kill_addr;
        w_drop_next      = 1'b0;
        w_valid_next     = r_valid;
        case (r_state)
            F_IDLE: begin
                w_state_next = F_FETCH;
            end
            F_FETCH: begin
                if (w_ack) begin
                    if (w_capture) begin
                        w_valid_next = 1'b1;
                        w_state_next = F_FULL;
                    end else begin
                        w_kill_next = 1'b0;
                        w_drop_next = 1'b1;
                    end
                end else if (redirect_i && w_req) begin
                    // Address must stay put until ack; remember the first one
                    w_kill_next = 1'b1;
                    if (!r_kill) begin
                        w_kill_addr_next = w_pc;
                    end
                end
            end
            F_FULL: begin
                if (redirect_i || !stall_i) begin
                    w_valid_next = 1'b0;
                    w_state_next = F_FETCH;
                end
            end
            default: begin
                w_state_next = F_IDLE;
            end
        endcase
    end

    // Control flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_kill      <= 1'b0;
            r_kill_addr <= '0;
            r_drop      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_kill      <= w_kill_next;
            r_kill_addr <= w_kill_addr_next;
            r_drop      <= w_drop_next;
            r_valid     <= w_valid_next;
        end
    end

    // Instruction output register, loaded only on an accepted ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_instr    <= '0;
            r_pc_out   <= '0;
            r_pc_plus4 <= '0;
        end else if (w_capture) begin
            r_instr    <= imem_data_i;
            r_pc_out   <= w_pc;
            r_pc_plus4 <= w_pc + c_pc_step;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_kill ? r_kill_addr : w_pc;
    assign valid_o     = r_valid;
    assign instr_o     = r_instr;
    assign pc_o        = r_pc_out;
    assign pc_plus4_o  = r_pc_plus4;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a latency-configurable
//            instruction memory and a program-order reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks    = 0;
    int n_errors    = 0;
    int n_delivered = 0;
    int mem_lat     = 1;
    int mem_cnt;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (mem_ack),
        .imem_data_i   (mem_data),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // Instruction memory: ack mem_lat cycles after the request is seen
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack  <= 1'b0;
            mem_cnt  <= 0;
            mem_data <= '0;
        end else if (mem_ack) begin
            mem_ack <= 1'b0;
            mem_cnt <= 0;
        end else if (imem_req) begin
            if (mem_cnt + 1 >= mem_lat) begin
                mem_ack  <= 1'b1;
                mem_data <= mem_word(imem_addr);
                mem_cnt  <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Reference model: program order. The next delivered instruction must be
    // the last redirect target, or the previous consumed pc + 4.
    initial begin : scoreboard
        logic [31:0] exp_pc, req_addr, pv_pc, pv_instr;
        bit          pv_valid, pv_req, pv_gone;
        exp_pc = 32'h0; req_addr = 32'h0; pv_pc = 32'h0; pv_instr = 32'h0;
        pv_valid = 1'b0; pv_req = 1'b0; pv_gone = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                exp_pc = 32'h0; pv_valid = 1'b0; pv_req = 1'b0; pv_gone = 1'b0;
            end else begin
                if (valid_o && !pv_valid) begin
                    n_checks++;
                    n_delivered++;
                    if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc) || pc_plus4_o !== exp_pc + 32'd4) begin
                        n_errors++;
                        $display("FAIL sb_instr: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                                 pc_o, instr_o, pc_plus4_o, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                    end
                end else if (valid_o) begin
                    n_checks++;
                    if (pv_gone || pc_o !== pv_pc || instr_o !== pv_instr) begin
                        n_errors++;
                        $display("FAIL sb_hold: valid pc=%h instr=%h, required held pc=%h instr=%h consumed=%0d",
                                 pc_o, instr_o, pv_pc, pv_instr, pv_gone);
                    end
                end
                if (imem_req && !pv_req) begin
                    n_checks++;
                    req_addr = imem_addr;
                    if (imem_addr !== exp_pc) begin
                        n_errors++;
                        $display("FAIL sb_req_addr: addr=%h, required %h", imem_addr, exp_pc);
                    end
                end
                if (imem_req && mem_ack) begin
                    n_checks++;
                    if (imem_addr !== req_addr) begin
                        n_errors++;
                        $display("FAIL sb_addr_stable: addr at ack=%h, required %h", imem_addr, req_addr);
                    end
                end
                pv_gone = 1'b0;
                if (redirect) begin
                    exp_pc  = redirect_pc & 32'hFFFF_FFFC;
                    pv_gone = valid_o;
                end else if (valid_o && !stall) begin
                    exp_pc  = pc_o + 32'd4;
                    pv_gone = 1'b1;
                end
                pv_valid = valid_o; pv_req = imem_req; pv_pc = pc_o; pv_instr = instr_o;
            end
        end
    end

    // Stimulus helper: hold reset across a scoreboard sample, release on negedge
    task automatic apply_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b0 || valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || pc_plus4_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h pc4=%h, required all 0",
                     imem_req, valid_o, instr_o, pc_o, pc_plus4_o);
        end
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_addr: addr=%h, required 0", imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        logic [31:0] instrs[$];
        bit          pv_req = 1'b0, pv_valid = 1'b0;
        mem_lat = 1;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (imem_req && !pv_req) addrs.push_back(imem_addr);
            if (valid_o && !pv_valid) begin
                pcs.push_back(pc_o);
                instrs.push_back(instr_o);
                n_checks++;
                if (pc_plus4_o !== pc_o + 32'd4) begin
                    n_errors++;
                    $display("FAIL seq_pc_plus4: pc4=%h, required %h", pc_plus4_o, pc_o + 32'd4);
                end
            end
            pv_req = imem_req; pv_valid = valid_o;
        end
        n_checks++;
        if (addrs.size() < 4 || pcs.size() < 4) begin
            n_errors++;
            $display("FAIL seq_count: requests=%0d fetches=%0d, required at least 4 each", addrs.size(), pcs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (addrs[k] !== 32'(4 * k) || pcs[k] !== 32'(4 * k) || instrs[k] !== mem_word(32'(4 * k))) begin
                    n_errors++;
                    $display("FAIL seq_fetch%0d: addr=%h pc=%h instr=%h, required addr=pc=%h instr=%h",
                             k, addrs[k], pcs[k], instrs[k], 32'(4 * k), mem_word(32'(4 * k)));
                end
            end
        end
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        mem_lat = 1;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            if (valid_o && pc_o == 32'h8) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL stall_reach: valid=%b pc=%h, required valid with pc 00000008", valid_o, pc_o);
            return;
        end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid_o !== 1'b1 || pc_o !== 32'h8 || instr_o !== mem_word(32'h8) || imem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold: valid=%b pc=%h instr=%h req=%b, required 1/00000008/%h/0",
                         valid_o, pc_o, instr_o, imem_req, mem_word(32'h8));
            end
        end
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || imem_addr !== 32'hC) begin
            n_errors++;
            $display("FAIL stall_next_addr: req=%b addr=%h, required 1/0000000c", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_full();
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0; stall = 1'b0;
        n_checks++;
        if (!found || valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL redir_full_flush: reached=%0d valid=%b, required 1/0", found, valid_o);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || imem_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL redir_full_addr: req=%b addr=%h, required 1/00000100", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_mid();
        bit held = 1'b1, acked = 1'b0, found = 1'b0;
        mem_lat = 3;
        apply_reset();
        redirect = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            n_errors++;
            $display("FAIL mid_first_req: req=%b addr=%h, required 1/00000010", imem_req, imem_addr);
        end
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) held = 1'b0;
            if (mem_ack) begin acked = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!held || !acked) begin
            n_errors++;
            $display("FAIL mid_addr_held: held=%0d acked=%0d, required 1/1", held, acked);
        end
        @(negedge clk);
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_discard: valid=%b, required 0", valid_o);
        end
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || imem_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL mid_next_addr: req=%b addr=%h, required 1/00000040", imem_req, imem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || pc_o !== 32'h40 || instr_o !== mem_word(32'h40)) begin
            n_errors++;
            $display("FAIL mid_target_fetch: valid=%b pc=%h instr=%h, required 1/00000040/%h",
                     valid_o, pc_o, instr_o, mem_word(32'h40));
        end
    endtask

    task automatic test_redirect_ack();
        bit found = 1'b0;
        mem_lat = 2;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            if (mem_ack) begin found = 1'b1; break; end
            @(negedge clk);
        end
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (!found || imem_req !== 1'b0 || valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_redir_discard: ack_seen=%0d req=%b valid=%b, required 1/0/0", found, imem_req, valid_o);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || imem_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL ack_redir_addr: req=%b addr=%h, required 1/00000200", imem_req, imem_addr);
        end
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h382;
        @(negedge clk);
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (valid_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || pc_o !== 32'h380 || instr_o !== mem_word(32'h380)) begin
            n_errors++;
            $display("FAIL ack_redir_last_wins: valid=%b pc=%h instr=%h, required 1/00000380/%h",
                     valid_o, pc_o, instr_o, mem_word(32'h380));
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        mem_lat = 3;
        apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || valid_o !== 1'b0 || imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL areset_mid_req: req=%b valid=%b addr=%h, required 0/0/0", imem_req, valid_o, imem_addr);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || pc_o !== 32'h0) begin
            n_errors++;
            $display("FAIL areset_restart: valid=%b pc=%h, required 1/00000000", valid_o, pc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || pc_plus4_o !== 32'h0) begin
            n_errors++;
            $display("FAIL areset_full: valid=%b instr=%h pc=%h pc4=%h, required all 0", valid_o, instr_o, pc_o, pc_plus4_o);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL areset_first_addr: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
        end
        // PC wrap-around at the top of the address space
        mem_lat = 1;
        apply_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found || pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_plus4: valid=%b pc=%h pc4=%h, required 1/fffffffc/00000000", valid_o, pc_o, pc_plus4_o);
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_next_addr: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        int start_delivered;
        apply_reset();
        start_delivered = n_delivered;
        for (int i = 0; i < 800; i++) begin
            mem_lat     = 1 + int'($urandom % 4);
            stall       = ($urandom % 3) == 0;
            redirect    = ($urandom % 10) == 0;
            redirect_pc = $urandom;
            @(negedge clk);
        end
        stall = 1'b0; redirect = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_delivered - start_delivered < 20) begin
            n_errors++;
            $display("FAIL random_progress: delivered=%0d, required at least 20", n_delivered - start_delivered);
        end
    endtask

    initial begin : watchdog
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_full();
        test_redirect_mid();
        test_redirect_ack();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
